// File: rtl/ifid_queue.sv
// ifid_queue: IF/ID circular queue with halt capture, flush and a registered head.
// The head outputs come from storage only, so a push reaches the ID stage one cycle later.
module ifid_queue #(
   parameter int                 INSTR_W    = 16,
   parameter int                 PC_W       = 16,
   parameter int                 DEPTH      = 2,
   parameter logic [INSTR_W-1:0] NOP_INSTR  = 16'h0800,
   parameter logic [INSTR_W-1:0] HALT_INSTR = 16'h0000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       IF_valid,
   input  logic [INSTR_W-1:0]         IF_instr,
   input  logic [PC_W-1:0]            IF_PC_Next,
   input  logic                       IF_err,
   output logic                       IF_ready,
   input  logic                       nHaltSig,
   input  logic                       flush,
   input  logic                       ID_stall,
   output logic                       IFID_valid,
   output logic [INSTR_W-1:0]         IFID_instr,
   output logic [PC_W-1:0]            IFID_PC_Next,
   output logic                       IFID_err,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);
   typedef enum logic {RUN, HALTED} state_t;
   state_t             r_state, w_next;
   logic [INSTR_W-1:0] r_instr [DEPTH];
   logic [PC_W-1:0]    r_pc [DEPTH];
   logic               r_err [DEPTH];
   logic [PW-1:0]      r_head, r_tail;
   logic [CW-1:0]      r_count;
   logic [PC_W-1:0]    r_last_pc;
   logic               w_push, w_pop, w_halted;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return p == PW'(DEPTH-1) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk)
      if (rst) r_state <= RUN;
      else r_state <= w_next;

   always_comb w_next = (r_state == RUN && w_push && nHaltSig) ? HALTED : r_state;

   always_comb w_halted = r_state == HALTED;

   assign count        = r_count;
   assign IFID_valid   = r_count != '0;
   assign IFID_instr   = IFID_valid ? r_instr[r_head] : NOP_INSTR;
   assign IFID_PC_Next = IFID_valid ? r_pc[r_head] : r_last_pc;
   assign IFID_err     = IFID_valid & r_err[r_head];
   assign w_pop        = IFID_valid & ~ID_stall;
   assign IF_ready     = ~w_halted & ~flush & ((r_count < CW'(DEPTH)) | w_pop);
   assign w_push       = IF_valid & IF_ready;

   always_ff @(posedge clk)
      if (w_push) begin
         r_instr[r_tail] <= nHaltSig ? HALT_INSTR : IF_instr;
         r_pc[r_tail]    <= IF_PC_Next;
         r_err[r_tail]   <= IF_err;
      end

   // r_last_pc tracks the head PC so an empty queue keeps showing the last one
   always_ff @(posedge clk)
      if (rst) begin
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_last_pc <= '0;
      end else begin
         if (IFID_valid) r_last_pc <= r_pc[r_head];
         if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) r_tail <= inc(r_tail);
            if (w_pop) r_head <= inc(r_head);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
         end
      end
endmodule

// File: tb/tb_ifid_queue.sv
// tb_ifid_queue: directed and random checks of ifid_queue against a queue-based model.
module tb_ifid_queue;
   localparam int DEPTH = 2;
   typedef struct {
      logic [15:0] instr;
      logic [15:0] pc;
      logic        err;
   } ent_t;
   logic clk = 0, rst = 1;
   logic IF_valid = 0, IF_err = 0, nHaltSig = 0, flush = 0, ID_stall = 0;
   logic [15:0] IF_instr = 0, IF_PC_Next = 0;
   logic IF_ready, IFID_valid, IFID_err;
   logic [15:0] IFID_instr, IFID_PC_Next;
   logic [1:0] count;
   ent_t m_q[$];
   bit m_halted = 0;
   logic [15:0] m_last_pc = 0;
   int checks = 0, errors = 0;

   ifid_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .IF_valid(IF_valid), .IF_instr(IF_instr),
      .IF_PC_Next(IF_PC_Next), .IF_err(IF_err), .IF_ready(IF_ready),
      .nHaltSig(nHaltSig), .flush(flush), .ID_stall(ID_stall),
      .IFID_valid(IFID_valid), .IFID_instr(IFID_instr),
      .IFID_PC_Next(IFID_PC_Next), .IFID_err(IFID_err), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_out();
      chk("valid", 32'(IFID_valid), 32'(m_q.size() != 0));
      chk("instr", 32'(IFID_instr), m_q.size() ? 32'(m_q[0].instr) : 32'h0800);
      chk("pc", 32'(IFID_PC_Next), m_q.size() ? 32'(m_q[0].pc) : 32'(m_last_pc));
      chk("err", 32'(IFID_err), m_q.size() ? 32'(m_q[0].err) : 32'd0);
      chk("count", 32'(count), 32'(m_q.size()));
   endtask

   task automatic do_reset();
      rst = 1; IF_valid = 0; flush = 0; ID_stall = 0; nHaltSig = 0;
      @(posedge clk);
      m_q.delete(); m_halted = 0; m_last_pc = 0;
      @(negedge clk);
      rst = 0;
      #1 chk("ready_rst", 32'(IF_ready), 32'd1);
      chk_out();
   endtask

   task automatic cyc(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                      input logic e, input logic h, input logic fl, input logic st);
      bit pop, push, rdy;
      ent_t ent;
      IF_valid = v; IF_instr = ins; IF_PC_Next = pc; IF_err = e;
      nHaltSig = h; flush = fl; ID_stall = st;
      #1;
      pop  = m_q.size() != 0 && !st;
      rdy  = !m_halted && !fl && (m_q.size() < DEPTH || pop);
      push = v && rdy;
      chk("ready", 32'(IF_ready), 32'(rdy));
      @(posedge clk);
      if (m_q.size() != 0) m_last_pc = m_q[0].pc;
      if (fl) m_q.delete();
      else begin
         if (pop) void'(m_q.pop_front());
         if (push) begin
            ent.instr = h ? 16'h0000 : ins;
            ent.pc = pc;
            ent.err = e;
            m_q.push_back(ent);
            if (h) m_halted = 1;
         end
      end
      @(negedge clk);
      chk_out();
   endtask

   initial begin
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      do_reset();
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(1, 16'h1234, 16'h0002, 0, 0, 0, 0);
      chk("A_head", 32'(IFID_instr), 32'h1234);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("A_gone", 32'(IFID_instr), 32'h0800);
      cyc(1, 16'h1111, 16'h0010, 0, 0, 0, 1);
      cyc(1, 16'h2222, 16'h0012, 0, 0, 0, 1);
      chk("full", 32'(count), 32'd2);
      cyc(1, 16'h9999, 16'h0099, 0, 0, 0, 1);
      cyc(1, 16'h3333, 16'h0014, 0, 0, 0, 0);
      chk("B_head", 32'(IFID_instr), 32'h2222);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("C_head", 32'(IFID_instr), 32'h3333);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(1, 16'h4444, 16'h0020, 0, 0, 0, 1);
      cyc(1, 16'h5555, 16'h0022, 0, 0, 0, 1);
      cyc(1, 16'h6666, 16'h0024, 0, 0, 1, 1);
      chk("flush_cnt", 32'(count), 32'd0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(1, 16'h7001, 16'h0030, 0, 0, 0, 1);
      cyc(1, 16'h7002, 16'h0032, 1, 0, 0, 1);
      chk("err0", 32'(IFID_err), 32'd0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("err1", 32'(IFID_err), 32'd1);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(1, 16'hABCD, 16'h0040, 0, 1, 0, 1);
      chk("halt_head", 32'(IFID_instr), 32'h0000);
      cyc(1, 16'h1212, 16'h0042, 0, 0, 0, 0);
      cyc(1, 16'h1313, 16'h0044, 0, 0, 0, 0);
      cyc(1, 16'h1414, 16'h0046, 0, 0, 1, 0);
      do_reset();
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 40) == 0) do_reset();
         else cyc($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 1'($urandom),
                  $urandom_range(0, 30) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 2) == 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
